aes_round_key_gen: RTL and testbench
====================================

Name: aes_round_key_gen

Overview:
- Iterative AES-128 key-schedule engine. Produces round keys 0..ROUNDS, one per accepted handshake, for the addRoundKey stage that feeds the byte-substitution stage.
- Holds only the current 128-bit round key and derives the next one on the fly. It instantiates the existing s_box module four times for SubWord.
- Replaces a precomputed 11x128-bit key table.

Parameters:
- ROUNDS, 10, index of the last round key produced. Legal range is 1..10; values outside it are unsupported. The default gives full AES-128.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin expansion of key_in; honoured only in IDLE
- key_in  in  128  cipher key, FIPS-197 byte order (key_in[127:120] = byte 0); sampled on an accepted start
- busy  out  1  high while in GEN
- rk_valid  out  1  rk_out/rk_round are valid
- rk_ready  in  1  consumer accepts the current round key
- rk_out  out  128  current round key, same byte order as key_in
- rk_round  out  4  index of rk_out, 0..ROUNDS
- done  out  1  one-cycle pulse after round key ROUNDS is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, busy=0, rk_valid=0, rk_out=0, rk_round=0, done=0, Rcon=8'h01.
- rst has priority over all inputs. Reset mid-expansion abandons the sequence, and no done pulse is issued.
- States: IDLE and GEN.
- IDLE, start=1: on that edge
  - rk_out<=key_in, rk_round<=0, Rcon<=8'h01
  - rk_valid<=1, busy<=1, state<=GEN
  - Round key 0 is visible the cycle after start, so latency is 1.
- IDLE, start=0: all outputs hold, done drops to 0.
- GEN, start: ignored.
- Handshake: a transfer occurs on an edge where rk_valid & rk_ready.
  - rk_out and rk_round must stay stable while rk_valid=1 and rk_ready=0.
  - No bubbles: with rk_ready held high, one round key per cycle. ROUNDS+1 keys take ROUNDS+1 consecutive cycles.
- Transfer with rk_round < ROUNDS:
  - rk_out<=next_key, rk_round<=rk_round+1, Rcon<=xtime(Rcon)
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). This gives the Rcon sequence 01,02,04,08,10,20,40,80,1b,36.
- Transfer with rk_round == ROUNDS:
  - rk_valid<=0, busy<=0, done<=1 for exactly one cycle, state<=IDLE
  - rk_out and rk_round hold their last values.
- next_key derivation (all XORs 32-bit; the key is four words w0=rk_out[127:96] .. w3=rk_out[31:0]):
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}, where RotWord(w) = {w[23:0],w[31:24]} and SubWord applies s_box to each byte.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - next_key = {n0,n1,n2,n3}.
- Timing: the S-box path is combinational from rk_out to the register input, giving a single-cycle round-key update.
- start coincident with done, i.e. in the cycle after the final transfer when state is already IDLE: accepted, a new expansion begins, and the done pulse still occurs.

Test Plan:
- FIPS-197 A.1: rst, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1.
  - Required response:
    - rk_round 0 -> 2b7e151628aed2a6abf7158809cf4f3c
    - 1 -> a0fafe1788542cb123a339392a6c7605
    - 2 -> f2c295f27a96b9435935807a7359f67f
    - 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
  - 11 consecutive valid cycles, done one cycle after round 10, busy low in the same cycle as done.
- Backpressure: same key, rk_ready driven with a random 30% duty.
  - rk_out/rk_round are stable whenever valid & !ready.
  - The key sequence is identical to the previous test, and the count of transfers is 11.
- start while busy: pulse start with key_in=all-ones at rk_round=4.
  - Ignored; the sequence continues with the A.1 keys.
- Reset mid-operation: assert rst at rk_round=6.
  - Next cycle: rk_valid=0, busy=0, rk_out=0, and no done pulse.
  - A new start with the A.1 key reproduces round key 1 = a0fafe17....
- Back-to-back expansions: start with key_in=000102030405060708090a0b0c0d0e0f, asserted in the cycle after done.
  - Round 10 key = 13111d7fe3944a17f307a78b4d2b30c5.
- ROUNDS=2 build: A.1 key.
  - Three keys, ending with f2c295f2..., then done.

Source files
------------

// File: rtl/aes_round_key_gen.sv
// Iterative AES-128 key schedule: holds one round key and derives the next
// on each accepted handshake, using four s_box instances for SubWord.

module s_box (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] LUT [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = LUT[in_i];

endmodule

module aes_round_key_gen #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic {
    IDLE,
    GEN
  } state_e;

  localparam logic [3:0] LAST = 4'(ROUNDS);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign w0  = key_q[127:96];
  assign w1  = key_q[95:64];
  assign w2  = key_q[63:32];
  assign w3  = key_q[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    s_box u_sbox (
      .in_i  (rot[8*g +: 8]),
      .out_o (sub[8*g +: 8])
    );
  end

  assign t        = sub ^ {rcon_q, 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd0;
          rcon_d  = 8'h01;
          state_d = GEN;
        end
      end
      GEN: begin
        if (rk_ready) begin
          if (round_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  // valid and busy coincide: a key is always on offer while generating
  assign busy     = (state_q == GEN);
  assign rk_valid = (state_q == GEN);
  assign rk_out   = key_q;
  assign rk_round = round_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Scoreboard bench for aes_round_key_gen against a FIPS-197 word-level
// key expansion model with a GF(2^8)-derived S-box.

module tb_aes_round_key_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  logic         start2 = 1'b0;
  logic [127:0] key2 = '0;
  logic         busy2, valid2, done2;
  logic         ready2 = 1'b1;
  logic [127:0] out2;
  logic [3:0]   round2;

  always #5 clk = ~clk;

  aes_round_key_gen #(.ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_out(rk_out), .rk_round(rk_round), .done(done)
  );

  aes_round_key_gen #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .key_in(key2),
    .busy(busy2), .rk_valid(valid2), .rk_ready(ready2),
    .rk_out(out2), .rk_round(round2), .done(done2)
  );

  localparam logic [127:0] K_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_B  = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct packed {
    logic [3:0]   r;
    logic [127:0] k;
  } exp_t;

  exp_t         sbq [$];
  logic [127:0] mk [0:10];
  logic [127:0] seen [0:10];
  int           total = 0;
  int           bad = 0;
  int           xfers = 0;
  bit           ready_mode = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // ---- reference model: FIPS-197 expansion with computed S-box ----
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
               ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb(tmp[31:24]), sb(tmp[23:16]),
               sb(tmp[15:8]), sb(tmp[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++)
      mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---- ready driver ----
  always @(posedge clk) begin
    #1;
    rk_ready = ready_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // ---- monitor ----
  bit           exp_done = 1'b0;
  bit           hold_v = 1'b0;
  logic [127:0] hold_k;
  logic [3:0]   hold_r;

  always @(negedge clk) begin
    bit   nxt;
    exp_t e;
    if (rst) begin
      exp_done = 1'b0;
      hold_v   = 1'b0;
    end else begin
      nxt = 1'b0;
      chk("done_pulse", done, exp_done);
      if (exp_done) chk("busy_at_done", busy, 1'b0);
      if (hold_v) begin
        chk("stall_valid", rk_valid, 1'b1);
        chk("stall_key", rk_out, hold_k);
        chk("stall_round", rk_round, hold_r);
      end
      if (rk_valid && rk_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got round=%0d want none",
                   rk_round);
        end else begin
          e = sbq.pop_front();
          chk("xfer_round", rk_round, e.r);
          chk("xfer_key", rk_out, e.k);
          seen[e.r] = rk_out;
          xfers++;
          if (e.r == 4'd10) nxt = 1'b1;
        end
      end
      hold_v   = rk_valid && !rk_ready;
      hold_k   = rk_out;
      hold_r   = rk_round;
      exp_done = nxt;
    end
  end

  // ---- stimulus helpers (called at a negedge) ----
  task automatic issue(input logic [127:0] k);
    expand(k);
    for (int r = 0; r <= 10; r++) sbq.push_back('{4'(r), mk[r]});
    start  = 1'b1;
    key_in = k;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int cyc, output int vcnt);
    cyc  = 0;
    vcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (rk_valid) vcnt++;
    end while (!done && cyc < lim);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done within %0d", lim);
    end
  endtask

  task automatic wait_round(input logic [3:0] r, input bit need_rdy);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rk_valid && rk_round == r && (!need_rdy || rk_ready))
               && n < 200);
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL round_timeout: got round=%0d want %0d", rk_round, r);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    int cyc, vcnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", rk_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key", rk_out, '0);
    chk("rst_round", rk_round, 4'd0);
    chk("rst_done", done, 1'b0);

    // FIPS-197 A.1 with continuous ready
    issue(K_A1);
    wait_done(40, cyc, vcnt);
    chk("a1_latency", cyc, 12);
    chk("a1_valid_cycles", vcnt, 11);
    chk("a1_r0", seen[0], K_A1);
    chk("a1_r1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_r2", seen[2], 128'hf2c295f27a96b9435935807a7359f67f);
    chk("a1_r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // backpressure
    repeat (2) @(negedge clk);
    ready_mode = 1'b1;
    xfers = 0;
    issue(K_A1);
    wait_done(400, cyc, vcnt);
    chk("bp_xfers", xfers, 11);
    chk("bp_r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    ready_mode = 1'b0;

    // start while busy is ignored
    repeat (2) @(negedge clk);
    issue(K_A1);
    wait_round(4'd4, 1'b0);
    start  = 1'b1;
    key_in = '1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40, cyc, vcnt);
    chk("busy_start_q", sbq.size(), 0);
    chk("busy_start_r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // reset mid-expansion
    repeat (2) @(negedge clk);
    issue(K_A1);
    wait_round(4'd5, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_valid", rk_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_key", rk_out, '0);
    chk("mid_rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    seen[1] = '0;
    issue(K_A1);
    wait_done(40, cyc, vcnt);
    chk("post_rst_r1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);

    // back-to-back: start in the done cycle
    issue(K_B);
    wait_done(40, cyc, vcnt);
    chk("b2b_r10", seen[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // random keys under random backpressure, chained back-to-back
    ready_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue({$urandom, $urandom, $urandom, $urandom});
      wait_done(400, cyc, vcnt);
    end
    ready_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rand_q_empty", sbq.size(), 0);

    // ROUNDS=2 instance
    expand(K_A1);
    start2 = 1'b1;
    key2   = K_A1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int r = 0; r <= 2; r++) begin
      @(negedge clk);
      chk("r2_valid", valid2, 1'b1);
      chk("r2_round", round2, 4'(r));
      chk("r2_key", out2, mk[r]);
    end
    chk("r2_last", out2, 128'hf2c295f27a96b9435935807a7359f67f);
    @(negedge clk);
    chk("r2_done", done2, 1'b1);
    chk("r2_valid_end", valid2, 1'b0);
    chk("r2_busy_end", busy2, 1'b0);
    @(negedge clk);
    chk("r2_done_drop", done2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
